// File: rtl/scarv_cop_cprs_gen.sv
// COP general-purpose register file: parametrised width/depth, three combinational
// read ports, byte-masked single or paired writes, sequenced scrub and optional bypass.
module scarv_cop_cprs_gen #(
   parameter int XLEN   = 32,
   parameter int NREG   = 16,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG),
   localparam int NB    = XLEN / 8
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   output logic            g_clk_req,
   input  logic            cprs_init,
   output logic            cprs_busy,
   input  logic            crs1_ren,
   input  logic [AW-1:0]   crs1_addr,
   output logic [XLEN-1:0] crs1_rdata,
   input  logic            crs2_ren,
   input  logic [AW-1:0]   crs2_addr,
   output logic [XLEN-1:0] crs2_rdata,
   input  logic            crs3_ren,
   input  logic [AW-1:0]   crs3_addr,
   output logic [XLEN-1:0] crs3_rdata,
   input  logic [NB-1:0]   crd_wen,
   input  logic            crd_wide,
   input  logic [AW-1:0]   crd_addr,
   input  logic [XLEN-1:0] crd_wdata,
   input  logic [XLEN-1:0] crd_wdata_hi,
   output logic            crd_err
);

   typedef enum logic {S_IDLE, S_SCRUB} state_t;

   state_t          r_state;
   logic [AW-1:0]   r_count;
   logic [XLEN-1:0] r_regs [NREG];
   logic            r_err;

   logic            w_anyWen;
   logic            w_accept;
   logic            w_busy;
   logic [AW-1:0]   w_hiAddr;
   logic [XLEN-1:0] w_loMerged;
   logic [XLEN-1:0] w_hiMerged;
   logic [2:0]      w_ren;
   logic [AW-1:0]   w_raddr [3];

   function automatic logic [XLEN-1:0] mergeLanes(input logic [XLEN-1:0] oldVal,
                                                  input logic [XLEN-1:0] newVal,
                                                  input logic [NB-1:0]   wen);
      logic [XLEN-1:0] result;
      for (int k = 0; k < NB; k++) begin
         result[8*k +: 8] = wen[k] ? newVal[8*k +: 8] : oldVal[8*k +: 8];
      end
      return result;
   endfunction

   // A paired write is only legal from an even address, so the high word's address is crd_addr with bit 0 set.
   assign w_busy     = (r_state == S_SCRUB);
   assign w_anyWen   = |crd_wen;
   assign w_accept   = w_anyWen & ~w_busy & ~cprs_init & (~crd_wide | ~crd_addr[0]);
   assign w_hiAddr   = crd_addr | AW'(1);
   assign w_loMerged = mergeLanes(r_regs[crd_addr], crd_wdata, crd_wen);
   assign w_hiMerged = mergeLanes(r_regs[w_hiAddr], crd_wdata_hi, crd_wen);

   assign cprs_busy  = w_busy;
   assign crd_err    = r_err;
   assign g_clk_req  = w_anyWen | cprs_init | w_busy | r_err;

   // Re-issuing init mid-scrub clears register 0 in that same cycle, so the restarted scrub still lasts NREG cycles.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_err   <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         r_err <= w_anyWen & ~w_accept;
         case (r_state)
            S_IDLE: begin
               if (cprs_init) begin
                  r_state <= S_SCRUB;
                  r_count <= '0;
               end else if (w_accept) begin
                  r_regs[crd_addr] <= w_loMerged;
                  if (crd_wide) begin
                     r_regs[w_hiAddr] <= w_hiMerged;
                  end
               end
            end
            S_SCRUB: begin
               if (cprs_init) begin
                  r_regs[0] <= '0;
                  r_count   <= AW'(1);
               end else begin
                  r_regs[r_count] <= '0;
                  if (r_count == AW'(NREG - 1)) begin
                     r_state <= S_IDLE;
                     r_count <= '0;
                  end else begin
                     r_count <= r_count + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_ren      = {crs3_ren, crs2_ren, crs1_ren};
   assign w_raddr[0] = crs1_addr;
   assign w_raddr[1] = crs2_addr;
   assign w_raddr[2] = crs3_addr;

   for (genvar p = 0; p < 3; p++) begin : g_read
      logic [XLEN-1:0] w_data;
      always_comb begin
         w_data = '0;
         if (w_ren[p] && !w_busy) begin
            w_data = r_regs[w_raddr[p]];
            if (BYPASS != 0 && w_accept) begin
               if (w_raddr[p] == crd_addr) begin
                  w_data = w_loMerged;
               end else if (crd_wide && w_raddr[p] == w_hiAddr) begin
                  w_data = w_hiMerged;
               end
            end
         end
      end
   end

   assign crs1_rdata = g_read[0].w_data;
   assign crs2_rdata = g_read[1].w_data;
   assign crs3_rdata = g_read[2].w_data;

endmodule

// File: tb/tb_scarv_cop_cprs_gen.sv
// Self-checking bench for scarv_cop_cprs_gen: directed vector table, scrub/reset
// sequences and randomized traffic against a behavioural register-file model.
module tb_scarv_cop_cprs_gen;

   localparam int XLEN = 32;
   localparam int NREG = 16;
   localparam int AW   = 4;
   localparam int NB   = 4;

   logic            g_clk = 1'b0;
   logic            g_resetn;
   logic            cprs_init;
   logic            crs1_ren, crs2_ren, crs3_ren;
   logic [AW-1:0]   crs1_addr, crs2_addr, crs3_addr;
   logic [NB-1:0]   crd_wen;
   logic            crd_wide;
   logic [AW-1:0]   crd_addr;
   logic [XLEN-1:0] crd_wdata, crd_wdata_hi;

   logic            aClkReq, aBusy, aErr;
   logic [XLEN-1:0] aRd1, aRd2, aRd3;
   logic            bClkReq, bBusy, bErr;
   logic [XLEN-1:0] bRd1, bRd2, bRd3;

   int checks = 0;
   int errors = 0;

   scarv_cop_cprs_gen #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dutBypass (
      .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(aClkReq),
      .cprs_init(cprs_init), .cprs_busy(aBusy),
      .crs1_ren(crs1_ren), .crs1_addr(crs1_addr), .crs1_rdata(aRd1),
      .crs2_ren(crs2_ren), .crs2_addr(crs2_addr), .crs2_rdata(aRd2),
      .crs3_ren(crs3_ren), .crs3_addr(crs3_addr), .crs3_rdata(aRd3),
      .crd_wen(crd_wen), .crd_wide(crd_wide), .crd_addr(crd_addr),
      .crd_wdata(crd_wdata), .crd_wdata_hi(crd_wdata_hi), .crd_err(aErr)
   );

   scarv_cop_cprs_gen #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dutNoBypass (
      .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(bClkReq),
      .cprs_init(cprs_init), .cprs_busy(bBusy),
      .crs1_ren(crs1_ren), .crs1_addr(crs1_addr), .crs1_rdata(bRd1),
      .crs2_ren(crs2_ren), .crs2_addr(crs2_addr), .crs2_rdata(bRd2),
      .crs3_ren(crs3_ren), .crs3_addr(crs3_addr), .crs3_rdata(bRd3),
      .crd_wen(crd_wen), .crd_wide(crd_wide), .crd_addr(crd_addr),
      .crd_wdata(crd_wdata), .crd_wdata_hi(crd_wdata_hi), .crd_err(bErr)
   );

   always #5 g_clk = ~g_clk;

   // Reference model: register contents, remaining scrub cycles, next register to clear, pending error pulse.
   logic [XLEN-1:0] mReg [NREG];
   int              mBusyLeft;
   int              mIdx;
   logic            mErr;

   typedef struct {
      logic [2:0]      ren;
      logic [AW-1:0]   raddr;
      logic [NB-1:0]   wen;
      logic            wide;
      logic [AW-1:0]   waddr;
      logic [XLEN-1:0] wdata;
      logic [XLEN-1:0] whi;
      logic [XLEN-1:0] e1, e2, e3, eNb;
      logic            eErr, eReq;
   } vec_t;

   vec_t vecs [10];

   task automatic checkVal(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] mergeModel(input logic [XLEN-1:0] oldVal,
                                                  input logic [XLEN-1:0] newVal,
                                                  input logic [NB-1:0]   wen);
      logic [XLEN-1:0] mask;
      mask = '0;
      for (int k = 0; k < NB; k++) if (wen[k]) mask = mask | (32'hFF << (8 * k));
      return (oldVal & ~mask) | (newVal & mask);
   endfunction

   function automatic logic modelAccepts();
      return (crd_wen != 0) && (mBusyLeft == 0) && !cprs_init && !(crd_wide && crd_addr[0]);
   endfunction

   function automatic logic [XLEN-1:0] expRead(input logic en, input logic [AW-1:0] a, input bit byp);
      logic [AW-1:0] hiA;
      hiA = crd_addr + AW'(1);
      if (!en || mBusyLeft > 0) return '0;
      if (byp && modelAccepts()) begin
         if (a == crd_addr) return mergeModel(mReg[a], crd_wdata, crd_wen);
         if (crd_wide && a == hiA) return mergeModel(mReg[a], crd_wdata_hi, crd_wen);
      end
      return mReg[a];
   endfunction

   task automatic resetModel();
      for (int i = 0; i < NREG; i++) mReg[i] = '0;
      mBusyLeft = 0;
      mIdx      = 0;
      mErr      = 1'b0;
   endtask

   task automatic advanceModel();
      logic acc;
      logic [AW-1:0] hiA;
      acc = modelAccepts();
      hiA = crd_addr + AW'(1);
      if (mBusyLeft > 0) begin
         if (cprs_init) begin
            mReg[0]   = '0;
            mIdx      = 1;
            mBusyLeft = NREG - 1;
         end else begin
            mReg[mIdx] = '0;
            mIdx++;
            mBusyLeft--;
         end
      end else if (cprs_init) begin
         mBusyLeft = NREG;
         mIdx      = 0;
      end else if (acc) begin
         mReg[crd_addr] = mergeModel(mReg[crd_addr], crd_wdata, crd_wen);
         if (crd_wide) mReg[hiA] = mergeModel(mReg[hiA], crd_wdata_hi, crd_wen);
      end
      mErr = (crd_wen != 0) && !acc;
   endtask

   task automatic applyStimulus(input logic [2:0] ren, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic [AW-1:0] a3, input logic [NB-1:0] wen, input logic wide,
                                input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                                input logic [XLEN-1:0] wh, input logic init);
      crs1_ren = ren[0]; crs2_ren = ren[1]; crs3_ren = ren[2];
      crs1_addr = a1; crs2_addr = a2; crs3_addr = a3;
      crd_wen = wen; crd_wide = wide; crd_addr = wa;
      crd_wdata = wd; crd_wdata_hi = wh; cprs_init = init;
      #1;
   endtask

   task automatic checkOutput();
      logic expBusy;
      logic expReq;
      expBusy = (mBusyLeft > 0);
      expReq  = (crd_wen != 0) | cprs_init | expBusy | mErr;
      checkVal("rd1Bypass", aRd1, expRead(crs1_ren, crs1_addr, 1'b1));
      checkVal("rd2Bypass", aRd2, expRead(crs2_ren, crs2_addr, 1'b1));
      checkVal("rd3Bypass", aRd3, expRead(crs3_ren, crs3_addr, 1'b1));
      checkVal("rd1NoBypass", bRd1, expRead(crs1_ren, crs1_addr, 1'b0));
      checkVal("rd2NoBypass", bRd2, expRead(crs2_ren, crs2_addr, 1'b0));
      checkVal("rd3NoBypass", bRd3, expRead(crs3_ren, crs3_addr, 1'b0));
      checkVal("busy", {31'b0, aBusy}, {31'b0, expBusy});
      checkVal("busyNoBypass", {31'b0, bBusy}, {31'b0, expBusy});
      checkVal("err", {31'b0, aErr}, {31'b0, mErr});
      checkVal("errNoBypass", {31'b0, bErr}, {31'b0, mErr});
      checkVal("clkReq", {31'b0, aClkReq}, {31'b0, expReq});
      checkVal("clkReqNoBypass", {31'b0, bClkReq}, {31'b0, expReq});
   endtask

   task automatic stepClock();
      advanceModel();
      @(negedge g_clk);
   endtask

   task automatic idleCycle();
      applyStimulus(3'b000, '0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
      checkOutput();
      stepClock();
   endtask

   task automatic fillRegs();
      for (int i = 0; i < NREG; i++) begin
         applyStimulus(3'b000, '0, '0, '0, 4'hF, 1'b0, AW'(i), {16'hC0DE, 16'(i + 1)}, '0, 1'b0);
         checkOutput();
         stepClock();
      end
   endtask

   // Pulse init, optionally re-pulse at a given busy cycle, and return how many cycles busy stayed high.
   task automatic runScrub(input int rePulseAt, output int busyCount);
      applyStimulus(3'b000, '0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
      checkOutput();
      stepClock();
      busyCount = 0;
      while (aBusy === 1'b1 && busyCount < 64) begin
         if (busyCount == 2) begin
            applyStimulus(3'b111, 4'd2, 4'd9, 4'd15, 4'hF, 1'b0, 4'd2, 32'hFFFF_FFFF, '0, 1'b0);
         end else begin
            applyStimulus(3'b111, AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)),
                          AW'($urandom_range(0, NREG - 1)), '0, 1'b0, '0, '0, '0, busyCount == rePulseAt);
         end
         checkOutput();
         checkVal("scrubReadZero", aRd1, '0);
         stepClock();
         if (busyCount == 2) checkVal("scrubDropErr", {31'b0, aErr}, 32'd1);
         busyCount++;
      end
      if (busyCount >= 64) begin
         errors++;
         $display("[TB] FAIL scrubTimeout: busy still %b after %0d cycles", aBusy, busyCount);
      end
   endtask

   initial begin
      int busyCount;

      g_resetn = 1'b0;
      applyStimulus(3'b000, '0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
      resetModel();
      @(negedge g_clk);
      g_resetn = 1'b1;

      vecs[0] = '{3'b000, 4'd0, 4'h0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
      vecs[1] = '{3'b111, 4'd3, 4'hF, 1'b0, 4'd3, 32'hDEADBEEF, 32'h0,
                  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1};
      vecs[2] = '{3'b101, 4'd3, 4'h0, 1'b0, 4'd0, 32'h0, 32'h0,
                  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[3] = '{3'b001, 4'd5, 4'hF, 1'b0, 4'd5, 32'h11223344, 32'h0,
                  32'h11223344, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
      vecs[4] = '{3'b111, 4'd5, 4'b0101, 1'b0, 4'd5, 32'hAABBCCDD, 32'h0,
                  32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 1'b0, 1'b1};
      vecs[5] = '{3'b111, 4'd5, 4'h0, 1'b0, 4'd0, 32'h0, 32'h0,
                  32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b0, 1'b0};
      vecs[6] = '{3'b111, 4'd7, 4'hF, 1'b1, 4'd6, 32'h01234567, 32'h89ABCDEF,
                  32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 32'h0, 1'b0, 1'b1};
      vecs[7] = '{3'b111, 4'd7, 4'hF, 1'b1, 4'd7, 32'h55555555, 32'h66666666,
                  32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 1'b0, 1'b1};
      vecs[8] = '{3'b111, 4'd6, 4'h0, 1'b0, 4'd0, 32'h0, 32'h0,
                  32'h01234567, 32'h01234567, 32'h01234567, 32'h01234567, 1'b1, 1'b1};
      vecs[9] = '{3'b111, 4'd7, 4'h0, 1'b0, 4'd0, 32'h0, 32'h0,
                  32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 1'b0, 1'b0};

      $display("[TB] directed vector table");
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].ren, vecs[v].raddr, vecs[v].raddr, vecs[v].raddr, vecs[v].wen,
                       vecs[v].wide, vecs[v].waddr, vecs[v].wdata, vecs[v].whi, 1'b0);
         checkOutput();
         checkVal($sformatf("vec%0d.rd1", v), aRd1, vecs[v].e1);
         checkVal($sformatf("vec%0d.rd2", v), aRd2, vecs[v].e2);
         checkVal($sformatf("vec%0d.rd3", v), aRd3, vecs[v].e3);
         checkVal($sformatf("vec%0d.rd1NoBypass", v), bRd1, vecs[v].eNb);
         checkVal($sformatf("vec%0d.err", v), {31'b0, aErr}, {31'b0, vecs[v].eErr});
         checkVal($sformatf("vec%0d.clkReq", v), {31'b0, aClkReq}, {31'b0, vecs[v].eReq});
         checkVal($sformatf("vec%0d.busy", v), {31'b0, aBusy}, 32'd0);
         stepClock();
      end

      $display("[TB] full scrub");
      fillRegs();
      runScrub(-1, busyCount);
      checkVal("scrubLength", busyCount, 32'd16);
      for (int i = 0; i < NREG; i++) begin
         applyStimulus(3'b111, AW'(i), AW'(i), AW'(i), '0, 1'b0, '0, '0, '0, 1'b0);
         checkOutput();
         checkVal($sformatf("postScrubR%0d", i), aRd1, '0);
         stepClock();
      end

      $display("[TB] scrub restarted at busy cycle 8");
      fillRegs();
      runScrub(8, busyCount);
      checkVal("restartScrubLength", busyCount, 32'd24);
      idleCycle();

      $display("[TB] reset in the middle of a scrub");
      fillRegs();
      applyStimulus(3'b000, '0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
      checkOutput();
      stepClock();
      for (int c = 0; c < 4; c++) idleCycle();
      checkVal("busyBeforeReset", {31'b0, aBusy}, 32'd1);
      g_resetn = 1'b0;
      resetModel();
      #1;
      checkVal("busyInReset", {31'b0, aBusy}, 32'd0);
      checkVal("busyInResetNoBypass", {31'b0, bBusy}, 32'd0);
      for (int i = 0; i < NREG; i++) begin
         applyStimulus(3'b111, AW'(i), AW'(i), AW'(i), '0, 1'b0, '0, '0, '0, 1'b0);
         checkVal($sformatf("resetR%0d", i), aRd1, '0);
         checkVal($sformatf("resetR%0dNoBypass", i), bRd2, '0);
      end
      @(negedge g_clk);
      g_resetn = 1'b1;
      idleCycle();

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++) begin
         applyStimulus(3'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
                       ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0,
                       $urandom_range(0, 3) == 0, AW'($urandom), $urandom, $urandom,
                       $urandom_range(0, 39) == 0);
         checkOutput();
         stepClock();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
